// File: rtl/operand_adder_pkg.sv
// rtl/operand_adder_pkg.sv - shared types and constants for the operand adder
package operand_adder_pkg;

  localparam int OPERAND_W   = 12;
  localparam int OPERAND_MAX = 999;
  localparam int SAT_W       = 10;
  localparam int SUM_W       = 11;
  localparam int BCD_W       = 16;
  localparam int CONV_CYCLES = 11;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    ADD,
    CONV,
    DONE
  } state_t;

  // Clamp a raw operand into the 0..999 range carried by the datapath.
  function automatic logic [SAT_W-1:0] saturate(input logic [OPERAND_W-1:0] v);
    if (v > OPERAND_W'(OPERAND_MAX)) begin
      return SAT_W'(OPERAND_MAX);
    end
    return v[SAT_W-1:0];
  endfunction

  function automatic logic over_range(input logic [OPERAND_W-1:0] v);
    return v > OPERAND_W'(OPERAND_MAX);
  endfunction

endpackage

// File: rtl/operand_adder_if.sv
// rtl/operand_adder_if.sv - operand entry and sum result bundle
interface operand_adder_if;
  import operand_adder_pkg::*;

  logic [OPERAND_W-1:0] number_in;
  logic                 number_valid;
  logic                 clear;
  logic [SUM_W-1:0]     sum_bin;
  logic [BCD_W-1:0]     sum_bcd;
  logic                 sum_valid;
  logic                 busy;
  logic                 operand_sel;
  logic                 range_err;

  modport master (
    output number_in, number_valid, clear,
    input  sum_bin, sum_bcd, sum_valid, busy, operand_sel, range_err
  );

  modport slave (
    input  number_in, number_valid, clear,
    output sum_bin, sum_bcd, sum_valid, busy, operand_sel, range_err
  );
endinterface

// File: rtl/operand_adder_bin2bcd_seq.sv
// rtl/operand_adder_bin2bcd_seq.sv - sequential double-dabble converter, one bit per cycle
module bin2bcd_seq #(
  parameter int BIN_W = 11,
  parameter int BCD_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt;
  logic             running;

  always_comb begin
    adj = scratch;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // done is high during the final shift so the caller can leave CONV on that same edge.
  assign done = running && (cnt == LAST);
  assign bcd  = scratch;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      running <= 1'b0;
      cnt     <= '0;
      bin_sh  <= '0;
      scratch <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      bin_sh  <= bin_in;
      scratch <= '0;
    end else if (running) begin
      {scratch, bin_sh} <= {adj, bin_sh} << 1;
      cnt               <= cnt + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_adder.sv
// rtl/operand_adder.sv - captures two operands, adds them and reports binary and BCD sums
module operand_adder
  import operand_adder_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  operand_adder_if.slave  bus
);

  state_t            state;
  logic              prev_valid;
  logic [SAT_W-1:0]  a_reg;
  logic [SAT_W-1:0]  b_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic [SUM_W-1:0]  add_result;
  logic [BCD_W-1:0]  eng_bcd;
  logic              eng_done;
  logic              capture;

  logic [SUM_W-1:0]  sum_bin_r;
  logic [BCD_W-1:0]  sum_bcd_r;
  logic              sum_valid_r;
  logic              busy_r;
  logic              operand_sel_r;
  logic              range_err_r;

  // A level held high produces a single capture; clear masks a coincident edge.
  assign capture    = bus.number_valid && !prev_valid && !bus.clear;
  assign add_result = SUM_W'(a_reg) + SUM_W'(b_reg);

  bin2bcd_seq #(
    .BIN_W (SUM_W),
    .BCD_W (BCD_W)
  ) u_conv (
    .clk    (clk),
    .reset  (reset),
    .abort  (bus.clear),
    .start  (state == ADD),
    .bin_in (add_result),
    .bcd    (eng_bcd),
    .done   (eng_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT_A;
      prev_valid    <= 1'b1;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      sum_bin_r     <= '0;
      sum_bcd_r     <= '0;
      sum_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      operand_sel_r <= 1'b0;
      range_err_r   <= 1'b0;
    end else begin
      prev_valid  <= bus.number_valid;
      sum_valid_r <= 1'b0;
      if (bus.clear) begin
        state         <= WAIT_A;
        a_reg         <= '0;
        b_reg         <= '0;
        busy_r        <= 1'b0;
        operand_sel_r <= 1'b0;
      end else begin
        case (state)
          WAIT_A: begin
            if (capture) begin
              a_reg         <= saturate(bus.number_in);
              range_err_r   <= range_err_r | over_range(bus.number_in);
              operand_sel_r <= 1'b1;
              state         <= WAIT_B;
            end
          end
          WAIT_B: begin
            if (capture) begin
              b_reg         <= saturate(bus.number_in);
              range_err_r   <= range_err_r | over_range(bus.number_in);
              operand_sel_r <= 1'b0;
              busy_r        <= 1'b1;
              state         <= ADD;
            end
          end
          ADD: begin
            sum_reg <= add_result;
            state   <= CONV;
          end
          CONV: begin
            if (eng_done) begin
              state <= DONE;
            end
          end
          DONE: begin
            sum_bin_r   <= sum_reg;
            sum_bcd_r   <= eng_bcd;
            sum_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state       <= WAIT_A;
          end
          default: begin
            state  <= WAIT_A;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sum_bin     = sum_bin_r;
  assign bus.sum_bcd     = sum_bcd_r;
  assign bus.sum_valid   = sum_valid_r;
  assign bus.busy        = busy_r;
  assign bus.operand_sel = operand_sel_r;
  assign bus.range_err   = range_err_r;

endmodule

// File: doc/operand_adder.md
OPERAND_ADDER -- requirements
Module: operand_adder

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port number_in  in  12  binary operand from the digit-entry stage (nominal 0..999).
REQ-004 SHALL have port number_valid  in  1  operand-ready flag; may be a pulse or a sticky level.
REQ-005 SHALL have port clear  in  1  synchronous abort; returns the block to WAIT_A.
REQ-006 SHALL have port sum_bin  out  11  binary sum A+B (0..1998).
REQ-007 SHALL have port sum_bcd  out  16  BCD sum: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-008 SHALL have port sum_valid  out  1  one-cycle pulse when sum_bin and sum_bcd are updated.
REQ-009 SHALL have port busy  out  1  high in ADD, CONV and DONE.
REQ-010 SHALL have port operand_sel  out  1  0 = awaiting A, 1 = awaiting B.
REQ-011 SHALL have port range_err  out  1  sticky; set when any captured operand exceeded 999.

Function
REQ-012 SHALL register number_valid each cycle; a capture event is a 0->1 transition (prev=0, cur=1), so a level held high counts once.
REQ-013 SHALL implement FSM states WAIT_A, WAIT_B, ADD, CONV, DONE.
REQ-014 WAIT_A: on capture event, SHALL register A and go to WAIT_B; operand_sel=0.
REQ-015 WAIT_B: on capture event, SHALL register B and go to ADD; operand_sel=1.
REQ-016 Operands above 999 SHALL be saturated to 999 at capture, and range_err SHALL be set.
REQ-017 ADD (1 cycle): SHALL compute the 11-bit A+B, latch it into the internal binary shift register, clear the 16-bit BCD scratch, zero the 4-bit iteration counter, and go to CONV.
REQ-018 CONV: SHALL run exactly 11 cycles of double dabble.
- Each cycle: add 3 to every scratch BCD digit >= 5.
- Then shift {scratch, binary} left by 1.
- After the 11th cycle, go to DONE.
REQ-019 DONE (1 cycle): SHALL load sum_bin and sum_bcd, pulse sum_valid=1, and return to WAIT_A.
REQ-020 Latency SHALL be fixed: sum_valid is high in the cycle beginning 13 rising edges after the edge that captured B.
REQ-021 sum_bin and sum_bcd SHALL hold their last value until the next DONE.
REQ-022 Capture events in ADD, CONV or DONE SHALL be ignored and SHALL NOT be queued.
REQ-023 clear SHALL take priority over every transition: state goes to WAIT_A, A/B are discarded, and sum outputs and range_err are retained.
REQ-024 A capture event coincident with clear SHALL be ignored.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL set:
- state = WAIT_A
- A = 0, B = 0
- sum_bin = 0, sum_bcd = 0x0000
- sum_valid = 0, busy = 0, operand_sel = 0, range_err = 0
- the edge-detect register = 1 (a level already high is not seen as an edge)
REQ-026 Reset asserted mid-CONV SHALL abort the conversion with no sum_valid pulse.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state enum
- OPERAND_MAX = 999
- SUM_W = 11, BCD_W = 16
- CONV_CYCLES = 11
REQ-028 The double-dabble engine SHALL be a sub-module bin2bcd_seq with a start/done handshake, parameterized by input width.

Verification
REQ-029 A=123, B=456 -> sum_valid pulse 13 clocks after B capture; sum_bin=579, sum_bcd=0x0579.
REQ-030 A=999, B=999 -> sum_bin=1998, sum_bcd=0x1998; A=0, B=0 -> 0x0000.
REQ-031 number_in=1665 captured as A, B=1 -> A saturated; sum_bcd=0x1000, range_err=1.
REQ-032 number_valid held high for 20 cycles -> exactly one capture (A only); operand_sel=1.
REQ-033 Reset asserted in the 5th CONV cycle -> no sum_valid; all outputs at reset values the next cycle.
REQ-034 Capture pulses during CONV, and clear during WAIT_B -> pulses ignored; after clear, state is WAIT_A and the old sum_bcd is retained.
